// File: rtl/sr_chain_loader.sv
// sr_chain_loader: loads one WIDTH-bit frame into a daisy-chained 74HC595
// string. Each frame clears the chain with MR, shifts the bits out on DS with
// one SHCP pulse per bit, then pulses STCP once to latch them.
//
// Optional feature: define SR_CHAIN_LOADER_FRAME_SEQ_EN to make frame_addr a
// frame index that advances 0..NFRAMES-1 once per frame. Without it,
// frame_addr is tied to 0.
//
// Handshake: start is a request that is only looked at while the FSM is idle
// (busy low). The cycle start is seen high in IDLE is the accept cycle: data is
// copied into a shadow register on that edge. busy rises on the next cycle.
// start and data are ignored from then until the FSM is back in IDLE. done
// pulses for one cycle when the frame has been latched. The next start can be
// accepted on the IDLE cycle right after done.
//
// All outputs are registered from the next-state decode, so the pins never
// glitch and always match the state register. The state register is r_state.
module sr_chain_loader #(
    parameter int WIDTH     = 49,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 0,
    parameter int NFRAMES   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             DS,
    output logic             SHCP,
    output logic             STCP,
    output logic             MR,
    output logic             busy,
    output logic             done,
    output logic [15:0]      frame_addr
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_LATCH    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // Reject parameter values the counters cannot represent.
    generate
        if (WIDTH < 1 || DIV < 1 || NFRAMES < 1) begin : g_bad_params
            $error("sr_chain_loader: WIDTH, DIV and NFRAMES must all be >= 1");
        end
    endgenerate

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] w_next_div_cnt;
    logic [IDX_W-1:0] r_bit_idx;
    logic [IDX_W-1:0] w_next_bit_idx;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_next_shadow;
    logic [IDX_W-1:0] w_bit_pos;
    logic             w_bit_val;
    logic             w_div_last;

    logic r_ds;
    logic r_shcp;
    logic r_stcp;
    logic r_mr;
    logic r_busy;
    logic r_done;

    assign w_div_last = (r_div_cnt == DIV_LAST);

    // Next-state, bit index and shadow capture. Every timed state lasts DIV cycles.
    always_comb begin
        w_next_state   = r_state;
        w_next_bit_idx = r_bit_idx;
        w_next_shadow  = r_shadow;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state  = S_CLEAR;
                    w_next_shadow = data;
                end
            end
            S_CLEAR: begin
                if (w_div_last) begin
                    w_next_state   = S_SHIFT_LO;
                    w_next_bit_idx = '0;
                end
            end
            S_SHIFT_LO: begin
                if (w_div_last) begin
                    w_next_state = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (w_div_last) begin
                    if (r_bit_idx == IDX_LAST) begin
                        w_next_state = S_LATCH;
                    end else begin
                        w_next_state   = S_SHIFT_LO;
                        w_next_bit_idx = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            S_LATCH: begin
                if (w_div_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        // Restart the divider on every state change. A timed state always
        // leaves at DIV_LAST, so the counter never wraps.
        if ((w_next_state != r_state) || (r_state == S_IDLE)) begin
            w_next_div_cnt = '0;
        end else begin
            w_next_div_cnt = r_div_cnt + CNT_W'(1);
        end
    end

    // Select which shadow bit goes on DS, following the shift order.
    always_comb begin
        w_bit_pos = (MSB_FIRST != 0) ? (IDX_LAST - w_next_bit_idx) : w_next_bit_idx;
        w_bit_val = w_next_shadow[w_bit_pos];
    end

    // State, counters and output pins. Outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_idx <= '0;
            r_shadow  <= '0;
            r_ds      <= 1'b0;
            r_shcp    <= 1'b0;
            r_stcp    <= 1'b0;
            r_mr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_div_cnt <= w_next_div_cnt;
            r_bit_idx <= w_next_bit_idx;
            r_shadow  <= w_next_shadow;
            r_ds      <= ((w_next_state == S_SHIFT_LO) || (w_next_state == S_SHIFT_HI)) ? w_bit_val : 1'b0;
            r_shcp    <= (w_next_state == S_SHIFT_HI);
            r_stcp    <= (w_next_state == S_LATCH);
            r_mr      <= (w_next_state != S_CLEAR);
            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= (w_next_state == S_DONE);
        end
    end

    assign DS   = r_ds;
    assign SHCP = r_shcp;
    assign STCP = r_stcp;
    assign MR   = r_mr;
    assign busy = r_busy;
    assign done = r_done;

`ifdef SR_CHAIN_LOADER_FRAME_SEQ_EN
    localparam logic [15:0] FRAME_LAST = 16'(NFRAMES - 1);

    logic [15:0] r_frame_addr;

    // Advance the frame index on the edge that closes DONE, wrapping after the last frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame_addr <= '0;
        end else if (r_state == S_DONE) begin
            r_frame_addr <= (r_frame_addr == FRAME_LAST) ? 16'd0 : (r_frame_addr + 16'd1);
        end
    end

    assign frame_addr = r_frame_addr;
`else
    assign frame_addr = 16'd0;
`endif

endmodule

// File: tb/tb_sr_chain_loader.sv
// tb_sr_chain_loader: directed bench for sr_chain_loader.
// u_a: WIDTH=8 DIV=2 LSB-first, u_b: WIDTH=8 DIV=2 MSB-first,
// u_c: WIDTH=4 DIV=1 LSB-first. All three use NFRAMES=3.
// A shared negedge monitor watches the DUT chosen by sel. It checks DS at every
// SHCP rise against exp_q and counts pulse widths and busy/idle runs.
module tb_sr_chain_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic [3:0] data_c = '0;

    logic ds_a, shcp_a, stcp_a, mr_a, busy_a, done_a;
    logic ds_b, shcp_b, stcp_b, mr_b, busy_b, done_b;
    logic ds_c, shcp_c, stcp_c, mr_c, busy_c, done_c;
    logic [15:0] fa_a, fa_b, fa_c;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    sr_chain_loader #(.WIDTH(8), .DIV(2), .MSB_FIRST(0), .NFRAMES(3)) u_a (
        .clk(clk), .reset(rst_n), .start(start_a), .data(data_a),
        .DS(ds_a), .SHCP(shcp_a), .STCP(stcp_a), .MR(mr_a),
        .busy(busy_a), .done(done_a), .frame_addr(fa_a)
    );
    sr_chain_loader #(.WIDTH(8), .DIV(2), .MSB_FIRST(1), .NFRAMES(3)) u_b (
        .clk(clk), .reset(rst_n), .start(start_b), .data(data_b),
        .DS(ds_b), .SHCP(shcp_b), .STCP(stcp_b), .MR(mr_b),
        .busy(busy_b), .done(done_b), .frame_addr(fa_b)
    );
    sr_chain_loader #(.WIDTH(4), .DIV(1), .MSB_FIRST(0), .NFRAMES(3)) u_c (
        .clk(clk), .reset(rst_n), .start(start_c), .data(data_c),
        .DS(ds_c), .SHCP(shcp_c), .STCP(stcp_c), .MR(mr_c),
        .busy(busy_c), .done(done_c), .frame_addr(fa_c)
    );

    // ---------------- monitor mux ----------------
    int   sel = 0;
    logic m_ds, m_shcp, m_stcp, m_mr, m_busy, m_done;
    assign m_ds   = (sel == 0) ? ds_a   : (sel == 1) ? ds_b   : ds_c;
    assign m_shcp = (sel == 0) ? shcp_a : (sel == 1) ? shcp_b : shcp_c;
    assign m_stcp = (sel == 0) ? stcp_a : (sel == 1) ? stcp_b : stcp_c;
    assign m_mr   = (sel == 0) ? mr_a   : (sel == 1) ? mr_b   : mr_c;
    assign m_busy = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    assign m_done = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic exp_q[$];
    int   len_q[$];
    int   gap_q[$];
    int   rise_cnt, stcp_rises, stcp_hi, mr_lo, done_cnt, frames, cur_len, idle_run;
    logic p_shcp, p_stcp, p_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        exp_q.delete();
        len_q.delete();
        gap_q.delete();
        rise_cnt = 0; stcp_rises = 0; stcp_hi = 0; mr_lo = 0;
        done_cnt = 0; frames = 0; cur_len = 0; idle_run = 0;
        p_shcp = m_shcp; p_stcp = m_stcp; p_busy = m_busy;
    endtask

    // Sample the selected DUT mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (m_busy && !p_busy) begin
            frames++;
            if (frames > 1) gap_q.push_back(idle_run);
            idle_run = 0;
        end
        if (!m_busy && p_busy) begin
            len_q.push_back(cur_len);
            cur_len  = 0;
            idle_run = 0;
        end
        if (m_busy) cur_len++;
        else        idle_run++;
        if (m_shcp && !p_shcp) begin
            rise_cnt++;
            if (exp_q.size() == 0) check_eq("ds_extra_rise", 32'd1, 32'd0);
            else                   check_eq("ds_at_rise", 32'(m_ds), 32'(exp_q.pop_front()));
        end
        if (m_stcp && !p_stcp) stcp_rises++;
        if (m_stcp) stcp_hi++;
        if (!m_mr) mr_lo++;
        if (m_done) done_cnt++;
        p_shcp = m_shcp; p_stcp = m_stcp; p_busy = m_busy;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // what: 0 = frames started, 1 = done pulses, 2 = SHCP rises
    task automatic wait_for(input int what, input int n, input string tag);
        int val;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            val = (what == 0) ? frames : (what == 1) ? done_cnt : rise_cnt;
            if (val >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check_eq(tag, 32'(val), 32'(n));
    endtask

    // exp_bits[k] is the DS value expected at the k-th SHCP rise.
    task automatic push_exp(input logic [7:0] exp_bits, input int w);
        logic [7:0] v;
        v = exp_bits;
        for (int k = 0; k < w; k++) exp_q.push_back(v[k]);
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        step();
        step();
        check_eq("rst_ds",   32'(ds_a),   32'd0);
        check_eq("rst_shcp", 32'(shcp_a), 32'd0);
        check_eq("rst_stcp", 32'(stcp_a), 32'd0);
        check_eq("rst_mr",   32'(mr_a),   32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_fa",   32'({fa_a, fa_b}), 32'd0);
        check_eq("rst_fa_c", 32'(fa_c), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("mr_after_rst_a", 32'(mr_a), 32'd1);
        check_eq("mr_after_rst_b", 32'(mr_b), 32'd1);
        check_eq("mr_after_rst_c", 32'(mr_c), 32'd1);
    endtask

    // One frame on u_a or u_b (WIDTH=8, DIV=2); checks shape and DS order.
    task automatic run_frame(input int s, input logic [7:0] d, input logic [7:0] exp_bits,
                             input int exp_busy, input int exp_pulse);
        sel = s;
        mon_clear();
        push_exp(exp_bits, 8);
        if (s == 0) begin data_a = d; start_a = 1'b1; end
        else        begin data_b = d; start_b = 1'b1; end
        step();
        start_a = 1'b0; start_b = 1'b0;
        wait_for(1, 1, "done_timeout");
        step(); step(); step();
        check_eq("shcp_rises", 32'(rise_cnt), 32'd8);
        check_eq("stcp_rises", 32'(stcp_rises), 32'd1);
        check_eq("stcp_width", 32'(stcp_hi), 32'(exp_pulse));
        check_eq("mr_low_cycles", 32'(mr_lo), 32'(exp_pulse));
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        check_eq("ds_bits_left", 32'(exp_q.size()), 32'd0);
        if (len_q.size() == 0) check_eq("busy_len", 32'd0, 32'(exp_busy));
        else                   check_eq("busy_len", 32'(len_q[0]), 32'(exp_busy));
    endtask

    // ---------------- main sequence ----------------
    int exp_fa [4];
    logic [7:0] seq_data [4];

    initial begin
`ifdef SR_CHAIN_LOADER_FRAME_SEQ_EN
        exp_fa = '{1, 2, 0, 1};
`else
        exp_fa = '{0, 0, 0, 0};
`endif
        seq_data = '{8'h01, 8'h80, 8'h5A, 8'hC3};

        reset_all();

        // LSB first, DIV=2: A5 gives 1,0,1,0,0,1,0,1 at the rises; busy 2*18+1 = 37.
        run_frame(0, 8'hA5, 8'hA5, 37, 2);
        run_frame(0, 8'h01, 8'h01, 37, 2);

        // MSB first: A5 gives bits 7..0 = 1,0,1,0,0,1,0,1; 01 gives a 1 only at the last rise;
        // C1 = 1100_0001 gives rises 1,1,0,0,0,0,0,1.
        run_frame(1, 8'hA5, 8'hA5, 37, 2);
        run_frame(1, 8'h01, 8'h80, 37, 2);
        run_frame(1, 8'hC1, 8'h83, 37, 2);

        // Back-to-back frames on u_c with start held high; data changes mid-frame.
        sel = 2;
        mon_clear();
        push_exp(8'h09, 4);
        push_exp(8'h06, 4);
        push_exp(8'h03, 4);
        data_c = 4'h9;
        start_c = 1'b1;
        wait_for(0, 1, "b2b_frame1_timeout");
        step(); step();
        data_c = 4'h6;
        wait_for(0, 2, "b2b_frame2_timeout");
        step(); step();
        data_c = 4'h3;
        wait_for(0, 3, "b2b_frame3_timeout");
        step();
        start_c = 1'b0;
        data_c = 4'hF;
        wait_for(1, 3, "b2b_done_timeout");
        step(); step(); step();
        check_eq("b2b_done_pulses", 32'(done_cnt), 32'd3);
        check_eq("b2b_shcp_rises", 32'(rise_cnt), 32'd12);
        check_eq("b2b_stcp_width", 32'(stcp_hi), 32'd3);
        check_eq("b2b_ds_left", 32'(exp_q.size()), 32'd0);
        check_eq("b2b_nframes", 32'(len_q.size()), 32'd3);
        foreach (len_q[i]) check_eq("b2b_busy_len", 32'(len_q[i]), 32'd11);
        check_eq("b2b_ngaps", 32'(gap_q.size()), 32'd2);
        foreach (gap_q[i]) check_eq("b2b_idle_gap", 32'(gap_q[i]), 32'd1);

        // Reset during SHIFT_HI of bit 3 on u_a, then a clean frame.
        sel = 0;
        mon_clear();
        push_exp(8'hFF, 8);
        data_a = 8'hFF;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_for(2, 4, "abort_rise_timeout");
        check_eq("abort_pre_shcp", 32'(shcp_a), 32'd1);
        rst_n = 1'b0;
        step();
        check_eq("abort_ds",   32'(ds_a),   32'd0);
        check_eq("abort_shcp", 32'(shcp_a), 32'd0);
        check_eq("abort_stcp", 32'(stcp_a), 32'd0);
        check_eq("abort_mr",   32'(mr_a),   32'd0);
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        check_eq("abort_done", 32'(done_a), 32'd0);
        check_eq("abort_fa",   32'(fa_a),   32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        step();
        check_eq("abort_mr_release", 32'(mr_a), 32'd1);
        for (int i = 0; i < 40; i++) step();
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        check_eq("abort_no_rises", 32'(rise_cnt), 32'd4);
        run_frame(0, 8'h3C, 8'h3C, 37, 2);

        // Frame sequencer: NFRAMES=3 wraps 1,2,0,1; stays 0 when disabled.
        reset_all();
        for (int f = 0; f < 4; f++) begin
            run_frame(0, seq_data[f], seq_data[f], 37, 2);
            check_eq("frame_addr", 32'(fa_a), 32'(exp_fa[f]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
